// File: rtl/fetch_redirect_tracer_pkg.sv
// Shared types for the stage0 fetch-control tracer: event kinds, capture
// modes, the record layout and the kind/mode filter.
package fetch_trace_pkg;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    KIND_SEQ    = 3'd0,
    KIND_JUMP   = 3'd1,
    KIND_FLUSH  = 3'd2,
    KIND_FENCE  = 3'd3,
    KIND_SFENCE = 3'd4,
    KIND_EPOCH  = 3'd5
  } trace_kind_e;

  typedef enum logic [1:0] {
    MODE_ALL        = 2'd0,
    MODE_CTRL       = 2'd1,
    MODE_EPOCH      = 2'd2,
    MODE_ALL_FREEZE = 2'd3
  } trace_mode_e;

  // Record layout for the default XLEN=64, TS_W=32 build; the tracer packs
  // its FIFO words in this same field order.
  typedef struct packed {
    trace_kind_e kind;
    logic [63:0] pc;
    logic [63:0] prev_pc;
    logic [1:0]  epochs;
    logic [31:0] ts;
  } trace_rec_t;

  // True when an event of kind k is captured under mode m.
  function automatic logic mode_pass(input trace_mode_e m, input trace_kind_e k);
    case (m)
      MODE_CTRL:  return (k == KIND_JUMP) || (k == KIND_FLUSH) ||
                         (k == KIND_FENCE) || (k == KIND_SFENCE);
      MODE_EPOCH: return (k == KIND_EPOCH);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_redirect_tracer_if.sv
// Trace record channel: valid/ready handshake plus the record fields.
// The tracer drives it through the master modport, the monitor through slave.
interface fetch_redirect_tracer_if #(
  parameter int XLEN = 64,
  parameter int TS_W = 32
);
  logic            o_rec_valid;
  logic            i_rec_ready;
  logic [2:0]      o_rec_kind;
  logic [XLEN-1:0] o_rec_pc;
  logic [XLEN-1:0] o_rec_prev_pc;
  logic [1:0]      o_rec_epochs;
  logic [TS_W-1:0] o_rec_ts;

  modport master (
    output o_rec_valid, o_rec_kind, o_rec_pc, o_rec_prev_pc, o_rec_epochs, o_rec_ts,
    input  i_rec_ready
  );

  modport slave (
    input  o_rec_valid, o_rec_kind, o_rec_pc, o_rec_prev_pc, o_rec_epochs, o_rec_ts,
    output i_rec_ready
  );
endinterface

// File: rtl/fetch_redirect_tracer_fifo.sv
// Synchronous FIFO for trace records. Push while full is accepted only when
// a pop happens in the same cycle; clear empties it and beats push/pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign rdata   = mem[rd_ptr];

  // Record storage; no reset, occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_redirect_tracer.sv
// Stage0 fetch-control tracer: classifies one event per cycle, filters it by
// mode, timestamps it and buffers it for a monitor on the record channel.
module fetch_redirect_tracer
  import fetch_trace_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int TS_W  = 32,
  parameter int OVF_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   i_enable,
  input  logic [1:0]             i_mode,
  input  logic                   i_clear,
  input  logic                   i_pc_en,
  input  logic [XLEN-1:0]        i_pc_d,
  input  logic [XLEN-1:0]        i_pc,
  input  logic                   i_flush,
  input  logic                   i_fence,
  input  logic                   i_sfence,
  input  logic                   i_eepoch,
  input  logic                   i_wepoch,
  fetch_redirect_tracer_if.master rec,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [OVF_W-1:0]       o_overflow,
  output logic                   o_frozen
);
  localparam int REC_W = 3 + 2*XLEN + 2 + TS_W;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [TS_W-1:0]  ts_p0;
  logic [1:0]       epochs_p0;
  logic [1:0]       epochs_p1;
  logic             primed_p1;
  logic             evt_vld;
  trace_kind_e      evt_kind;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rec_vld;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] rdata;

  assign epochs_p0 = {i_wepoch, i_eepoch};

  // Event classification, highest priority first; the epoch compare is
  // suppressed until the previous-epoch register has been primed.
  always_comb begin
    evt_vld  = 1'b1;
    evt_kind = KIND_SEQ;
    if (i_flush)                                    evt_kind = KIND_FLUSH;
    else if (i_sfence)                              evt_kind = KIND_SFENCE;
    else if (i_fence)                               evt_kind = KIND_FENCE;
    else if (primed_p1 && (epochs_p0 != epochs_p1)) evt_kind = KIND_EPOCH;
    else if (i_pc_en)
      evt_kind = (i_pc_d == i_pc + XLEN'(PC_STEP)) ? KIND_SEQ : KIND_JUMP;
    else
      evt_vld = 1'b0;
  end

  assign push_req = evt_vld && mode_pass(trace_mode_e'(i_mode), evt_kind) &&
                    i_enable && !o_frozen && !i_clear;
  assign rec_vld  = !fifo_empty;
  assign pop      = rec_vld && rec.i_rec_ready;
  assign drop     = push_req && fifo_full && !pop;
  assign wdata    = {evt_kind, i_pc_d, i_pc, epochs_p0, ts_p0};

  // Timestamp, epoch history, drop accounting and freeze flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ts_p0      <= '0;
      epochs_p1  <= '0;
      primed_p1  <= 1'b0;
      o_overflow <= '0;
      o_frozen   <= 1'b0;
    end else begin
      ts_p0     <= ts_p0 + 1'b1;
      epochs_p1 <= epochs_p0;
      primed_p1 <= 1'b1;
      if (i_clear) begin
        o_overflow <= '0;
        o_frozen   <= 1'b0;
      end else if (drop) begin
        if (trace_mode_e'(i_mode) == MODE_ALL_FREEZE) o_frozen <= 1'b1;
        else                                          o_overflow <= sat_inc(o_overflow);
      end
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_req),
    .pop   (pop),
    .clear (i_clear),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  assign rec.o_rec_valid   = rec_vld;
  assign rec.o_rec_kind    = rec_vld ? rdata[REC_W-1 -: 3]           : '0;
  assign rec.o_rec_pc      = rec_vld ? rdata[REC_W-4 -: XLEN]        : '0;
  assign rec.o_rec_prev_pc = rec_vld ? rdata[REC_W-4-XLEN -: XLEN]   : '0;
  assign rec.o_rec_epochs  = rec_vld ? rdata[TS_W+1 -: 2]            : '0;
  assign rec.o_rec_ts      = rec_vld ? rdata[TS_W-1:0]               : '0;
endmodule

// File: tb/tb_fetch_redirect_tracer.sv
// Bench for fetch_redirect_tracer: directed scenarios plus a random run,
// all checked against a queue-based reference model of the trace buffer.
module tb_fetch_redirect_tracer;
  import fetch_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        i_enable;
  logic [1:0]  i_mode;
  logic        i_clear;
  logic        i_pc_en;
  logic [63:0] i_pc_d;
  logic [63:0] i_pc;
  logic        i_flush;
  logic        i_fence;
  logic        i_sfence;
  logic        i_eepoch;
  logic        i_wepoch;
  logic [4:0]  o_count;
  logic [15:0] o_overflow;
  logic        o_frozen;

  fetch_redirect_tracer_if #(.XLEN(64), .TS_W(32)) rec_if ();

  fetch_redirect_tracer #(.XLEN(64), .DEPTH(DEPTH), .TS_W(32), .OVF_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .i_enable(i_enable), .i_mode(i_mode), .i_clear(i_clear),
    .i_pc_en(i_pc_en), .i_pc_d(i_pc_d), .i_pc(i_pc), .i_flush(i_flush), .i_fence(i_fence),
    .i_sfence(i_sfence), .i_eepoch(i_eepoch), .i_wepoch(i_wepoch), .rec(rec_if),
    .o_count(o_count), .o_overflow(o_overflow), .o_frozen(o_frozen)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model state
  trace_rec_t  q[$];
  int          m_ovf;
  bit          m_frozen;
  bit          m_primed;
  logic [1:0]  m_prev;
  logic [31:0] m_ts;

  function automatic int classify();
    if (i_flush)  return 2;
    if (i_sfence) return 4;
    if (i_fence)  return 3;
    if (m_primed && ({i_wepoch, i_eepoch} != m_prev)) return 5;
    if (i_pc_en)  return (i_pc_d == i_pc + 64'd4) ? 0 : 1;
    return -1;
  endfunction

  function automatic bit passes(int kind, int mode);
    if (mode == 1) return (kind >= 1) && (kind <= 4);
    if (mode == 2) return kind == 5;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_frozen = 0; m_primed = 0; m_prev = 2'b00; m_ts = 0;
  endtask

  // Scoreboard comparison of the registered state, then one clock of model+DUT.
  task automatic step();
    trace_rec_t exp_r, r;
    int  kind;
    bit  pop, push, full;
    checks++;
    if (rec_if.o_rec_valid !== (q.size() != 0) || o_count !== 5'(q.size()) ||
        o_overflow !== 16'(m_ovf) || o_frozen !== m_frozen) begin
      failures++;
      $display("FAIL state t=%0t: valid=%0b count=%0d ovf=%0d frozen=%0b, expected valid=%0b count=%0d ovf=%0d frozen=%0b",
               $time, rec_if.o_rec_valid, o_count, o_overflow, o_frozen,
               q.size() != 0, q.size(), m_ovf, m_frozen);
    end
    exp_r = (q.size() != 0) ? q[0] : '0;
    checks++;
    if ({rec_if.o_rec_kind, rec_if.o_rec_pc, rec_if.o_rec_prev_pc, rec_if.o_rec_epochs, rec_if.o_rec_ts} !== exp_r) begin
      failures++;
      $display("FAIL record t=%0t: kind=%0d pc=%h prev=%h ep=%b ts=%0d, expected kind=%0d pc=%h prev=%h ep=%b ts=%0d",
               $time, rec_if.o_rec_kind, rec_if.o_rec_pc, rec_if.o_rec_prev_pc, rec_if.o_rec_epochs, rec_if.o_rec_ts,
               exp_r.kind, exp_r.pc, exp_r.prev_pc, exp_r.epochs, exp_r.ts);
    end
    if (!RST_N) begin
      model_reset();
    end else begin
      kind = classify();
      if (i_clear) begin
        q.delete(); m_ovf = 0; m_frozen = 0;
      end else begin
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && rec_if.i_rec_ready;
        push = (kind >= 0) && passes(kind, int'(i_mode)) && i_enable && !m_frozen;
        if (pop) void'(q.pop_front());
        if (push) begin
          if (full && !pop) begin
            if (i_mode == 2'd3) m_frozen = 1;
            else if (m_ovf < 65535) m_ovf++;
          end else begin
            r.kind = trace_kind_e'(kind);
            r.pc = i_pc_d; r.prev_pc = i_pc; r.epochs = {i_wepoch, i_eepoch}; r.ts = m_ts;
            q.push_back(r);
          end
        end
      end
      m_prev = {i_wepoch, i_eepoch};
      m_primed = 1;
      m_ts++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    i_pc_en = 0; i_flush = 0; i_fence = 0; i_sfence = 0; i_clear = 0;
  endtask

  task automatic seq_event(input logic [63:0] pc);
    i_pc_en = 1; i_pc = pc; i_pc_d = pc + 64'd4;
    step();
  endtask

  task automatic test_reset();
    RST_N = 0; i_enable = 0; i_mode = 0; i_eepoch = 0; i_wepoch = 0;
    i_pc = 0; i_pc_d = 0; rec_if.i_rec_ready = 0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    checks++;
    if (rec_if.o_rec_valid !== 1'b0 || o_count !== 5'd0 || o_overflow !== 16'd0 || o_frozen !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b count=%0d ovf=%0d frozen=%0b, expected all 0",
               rec_if.o_rec_valid, o_count, o_overflow, o_frozen);
    end
    checks++;
    if (rec_if.o_rec_kind !== 3'd0 || rec_if.o_rec_pc !== 64'd0 || rec_if.o_rec_ts !== 32'd0) begin
      failures++;
      $display("FAIL reset_fields: kind=%0d pc=%h ts=%0d, expected 0", rec_if.o_rec_kind, rec_if.o_rec_pc, rec_if.o_rec_ts);
    end
    RST_N = 1;
  endtask

  task automatic test_seq_jump();
    logic [31:0] ts0;
    i_enable = 1; i_mode = 0; rec_if.i_rec_ready = 0;
    i_pc_en = 1; i_pc = 64'h1000; i_pc_d = 64'h1004; step();
    i_pc = 64'h1004; i_pc_d = 64'h2000; step();
    idle(); step();
    checks++;
    if (o_count !== 5'd2 || rec_if.o_rec_kind !== 3'd0 || rec_if.o_rec_pc !== 64'h1004 || rec_if.o_rec_prev_pc !== 64'h1000) begin
      failures++;
      $display("FAIL seq_record: count=%0d kind=%0d pc=%h prev=%h, expected 2 0 1004 1000",
               o_count, rec_if.o_rec_kind, rec_if.o_rec_pc, rec_if.o_rec_prev_pc);
    end
    ts0 = rec_if.o_rec_ts;
    rec_if.i_rec_ready = 1; step();
    checks++;
    if (rec_if.o_rec_kind !== 3'd1 || rec_if.o_rec_pc !== 64'h2000 || rec_if.o_rec_prev_pc !== 64'h1004 ||
        rec_if.o_rec_ts !== ts0 + 32'd1) begin
      failures++;
      $display("FAIL jump_record: kind=%0d pc=%h prev=%h ts=%0d, expected 1 2000 1004 ts=%0d",
               rec_if.o_rec_kind, rec_if.o_rec_pc, rec_if.o_rec_prev_pc, rec_if.o_rec_ts, ts0 + 32'd1);
    end
    step();
    rec_if.i_rec_ready = 0;
    i_pc_en = 1; i_pc = 64'hFFFF_FFFF_FFFF_FFFC; i_pc_d = 64'h0; step();
    idle(); step();
    checks++;
    if (rec_if.o_rec_kind !== 3'd0 || rec_if.o_rec_pc !== 64'h0) begin
      failures++;
      $display("FAIL pc_wrap_seq: kind=%0d pc=%h, expected 0 0", rec_if.o_rec_kind, rec_if.o_rec_pc);
    end
    rec_if.i_rec_ready = 1; step(); rec_if.i_rec_ready = 0;
  endtask

  task automatic test_priority();
    i_mode = 0;
    i_flush = 1; i_eepoch = ~i_eepoch; step();
    idle(); step(); step();
    checks++;
    if (o_count !== 5'd1 || rec_if.o_rec_kind !== 3'd2) begin
      failures++;
      $display("FAIL flush_priority: count=%0d kind=%0d, expected 1 2", o_count, rec_if.o_rec_kind);
    end
    rec_if.i_rec_ready = 1; step(); rec_if.i_rec_ready = 0;
  endtask

  task automatic test_ctrl_filter();
    i_mode = 1;
    for (int i = 0; i < 3; i++) seq_event(64'h3000 + 64'(4*i));
    idle(); i_fence = 1; step();
    idle(); step();
    checks++;
    if (o_count !== 5'd1 || rec_if.o_rec_kind !== 3'd3 || o_overflow !== 16'd0) begin
      failures++;
      $display("FAIL ctrl_filter: count=%0d kind=%0d ovf=%0d, expected 1 3 0", o_count, rec_if.o_rec_kind, o_overflow);
    end
    rec_if.i_rec_ready = 1; step(); rec_if.i_rec_ready = 0;
    i_mode = 0;
  endtask

  task automatic test_overflow();
    logic [31:0] ts0;
    i_mode = 0; rec_if.i_rec_ready = 0;
    for (int i = 0; i < 20; i++) seq_event(64'h4000 + 64'(4*i));
    idle(); step();
    checks++;
    if (o_count !== 5'd16 || o_overflow !== 16'd4) begin
      failures++;
      $display("FAIL overflow_count: count=%0d ovf=%0d, expected 16 4", o_count, o_overflow);
    end
    rec_if.i_rec_ready = 1;
    ts0 = rec_if.o_rec_ts;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rec_if.o_rec_valid !== 1'b1 || rec_if.o_rec_ts !== ts0 + 32'(i) || rec_if.o_rec_pc !== 64'h4004 + 64'(4*i)) begin
        failures++;
        $display("FAIL drain_order[%0d]: valid=%0b ts=%0d pc=%h, expected 1 ts=%0d pc=%h",
                 i, rec_if.o_rec_valid, rec_if.o_rec_ts, rec_if.o_rec_pc, ts0 + 32'(i), 64'h4004 + 64'(4*i));
      end
      step();
    end
    checks++;
    if (o_count !== 5'd0 || rec_if.o_rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: count=%0d valid=%0b, expected 0 0", o_count, rec_if.o_rec_valid);
    end
    rec_if.i_rec_ready = 0;
  endtask

  task automatic test_freeze();
    i_clear = 1; step(); i_clear = 0;
    i_mode = 3; rec_if.i_rec_ready = 0;
    for (int i = 0; i < 17; i++) seq_event(64'h5000 + 64'(4*i));
    idle(); step();
    checks++;
    if (o_frozen !== 1'b1 || o_overflow !== 16'd0 || o_count !== 5'd16) begin
      failures++;
      $display("FAIL freeze_set: frozen=%0b ovf=%0d count=%0d, expected 1 0 16", o_frozen, o_overflow, o_count);
    end
    rec_if.i_rec_ready = 1;
    for (int i = 0; i < 3; i++) seq_event(64'h6000 + 64'(4*i));
    rec_if.i_rec_ready = 0;
    idle(); step();
    checks++;
    if (o_count !== 5'd13 || o_frozen !== 1'b1) begin
      failures++;
      $display("FAIL freeze_ignores: count=%0d frozen=%0b, expected 13 1", o_count, o_frozen);
    end
    i_clear = 1; step(); i_clear = 0;
    checks++;
    if (o_count !== 5'd0 || o_frozen !== 1'b0 || rec_if.o_rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL freeze_clear: count=%0d frozen=%0b valid=%0b, expected 0 0 0", o_count, o_frozen, rec_if.o_rec_valid);
    end
    i_mode = 0;
  endtask

  task automatic test_reset_mid_drain();
    i_mode = 0; rec_if.i_rec_ready = 0;
    for (int i = 0; i < 5; i++) seq_event(64'h7000 + 64'(4*i));
    idle(); step();
    checks++;
    if (o_count !== 5'd5) begin
      failures++;
      $display("FAIL pre_reset_count: count=%0d, expected 5", o_count);
    end
    rec_if.i_rec_ready = 1; RST_N = 0; step();
    checks++;
    if (rec_if.o_rec_valid !== 1'b0 || o_count !== 5'd0 || o_overflow !== 16'd0 || o_frozen !== 1'b0 || rec_if.o_rec_ts !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset: valid=%0b count=%0d ovf=%0d frozen=%0b ts=%0d, expected all 0",
               rec_if.o_rec_valid, o_count, o_overflow, o_frozen, rec_if.o_rec_ts);
    end
    RST_N = 1; rec_if.i_rec_ready = 0;
    i_wepoch = 1; i_eepoch = 0; step();
    step();
    checks++;
    if (o_count !== 5'd0) begin
      failures++;
      $display("FAIL priming_no_epoch: count=%0d, expected 0", o_count);
    end
    i_eepoch = 1; step();
    step();
    checks++;
    if (o_count !== 5'd1 || rec_if.o_rec_kind !== 3'd5 || rec_if.o_rec_epochs !== 2'b11) begin
      failures++;
      $display("FAIL epoch_event: count=%0d kind=%0d ep=%b, expected 1 5 11", o_count, rec_if.o_rec_kind, rec_if.o_rec_epochs);
    end
    rec_if.i_rec_ready = 1; step(); rec_if.i_rec_ready = 0;
  endtask

  task automatic test_random();
    logic [63:0] pc;
    pc = 64'h8000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 29) == 0) i_mode = 2'($urandom_range(0, 3));
      i_enable = ($urandom_range(0, 9) != 0);
      i_clear  = ($urandom_range(0, 59) == 0);
      RST_N    = ($urandom_range(0, 299) != 0);
      rec_if.i_rec_ready = ($urandom_range(0, 2) == 0);
      i_flush  = ($urandom_range(0, 19) == 0);
      i_fence  = ($urandom_range(0, 19) == 0);
      i_sfence = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) i_eepoch = ~i_eepoch;
      if ($urandom_range(0, 14) == 0) i_wepoch = ~i_wepoch;
      i_pc_en = ($urandom_range(0, 9) < 6);
      i_pc = pc;
      i_pc_d = ($urandom_range(0, 9) < 7) ? pc + 64'd4 : {$urandom, $urandom};
      if (i_pc_en) pc = i_pc_d;
      step();
    end
    RST_N = 1; idle(); i_enable = 0; rec_if.i_rec_ready = 1;
    for (int n = 0; n < DEPTH + 2; n++) step();
  endtask

  initial begin
    test_reset();
    test_seq_jump();
    test_priority();
    test_ctrl_filter();
    test_overflow();
    test_freeze();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
